// File: rtl/nes_dma_pkg.sv
// Shared types and constants for the NES sprite (OAM) DMA controller.
// Optional build macro: OAM_DMA_PARITY_ALIGN_EN (enables APU-parity alignment).
package nes_dma_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] OAM_DMA_REG  = 16'h4014;
  localparam logic [15:0] OAM_DATA_REG = 16'h2004;
  localparam int          DMA_XFER_LEN = 256;

endpackage

// File: rtl/apu_cyc_parity.sv
// Free-running APU cycle parity flop; kept separate so the APU can share it.
// Built only when OAM_DMA_PARITY_ALIGN_EN is defined.
`ifdef OAM_DMA_PARITY_ALIGN_EN
module apu_cyc_parity (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic odd_o
);

  logic odd_q;

  // Toggle every clock; reset puts the phase back to even.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) odd_q <= 1'b0;
    else          odd_q <= ~odd_q;
  end

  assign odd_o = odd_q;

endmodule
`endif

// File: rtl/oam_dma_ctl.sv
// Sprite DMA controller: a write to the trigger register halts the CPU and
// copies one 256-byte page into PPU OAM via the OAM data port.
// Optional build macro: OAM_DMA_PARITY_ALIGN_EN (adds ALIGN state so READs
// land on even APU cycles; without it HALT goes straight to READ).
module oam_dma_ctl
  import nes_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = OAM_DMA_REG,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_REG,
  parameter int          XFER_LEN      = DMA_XFER_LEN
) (
  input  logic        clk_i,
  input  logic        b_rst_i,
  input  logic [15:0] cpu_addr_i,
  input  logic        cpu_wr_i,
  input  logic [7:0]  cpu_dout_i,
  input  logic        cpu_halted_i,
  input  logic [7:0]  bus_din_i,
  output logic        dma_bflg_o,
  output logic [7:0]  dma_by_o,
  output logic [15:0] bus_addr_o,
  output logic        bus_rd_o,
  output logic        bus_wr_o,
  output logic [7:0]  bus_dout_o,
  output logic        dma_done_o
);

  localparam logic [7:0] LAST_BY = 8'(XFER_LEN - 1);

  dma_state_t  state_q;
  logic [7:0]  page_q, data_q, by_q, dout_q;
  logic [15:0] addr_q;
  logic        bflg_q, rd_q, wr_q, done_q;
  logic        trig;
  logic [7:0]  nxt_by;

`ifdef OAM_DMA_PARITY_ALIGN_EN
  logic apu_odd;

  apu_cyc_parity u_parity (
    .clk_i   (clk_i),
    .rst_n_i (b_rst_i),
    .odd_o   (apu_odd)
  );
`endif

  assign trig   = cpu_wr_i && (cpu_addr_i == DMA_REG_ADDR);
  // Byte index wraps within the page; it never carries into page_q.
  assign nxt_by = by_q + 8'd1;

  // Transfer FSM; outputs are registered for the state being entered.
  always_ff @(posedge clk_i) begin
    if (!b_rst_i) begin
      state_q <= IDLE;
      page_q  <= '0;
      data_q  <= '0;
      by_q    <= '0;
      bflg_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      dout_q <= '0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (trig) begin
            page_q  <= cpu_dout_i;
            by_q    <= '0;
            bflg_q  <= 1'b1;
            state_q <= HALT;
          end
        end
        HALT: begin
          // Bus is ours only once the CU acknowledges the halt.
          if (cpu_halted_i) begin
`ifdef OAM_DMA_PARITY_ALIGN_EN
            if (apu_odd) begin
              state_q <= READ;
              rd_q    <= 1'b1;
              addr_q  <= {page_q, by_q};
            end else begin
              state_q <= ALIGN;
            end
`else
            state_q <= READ;
            rd_q    <= 1'b1;
            addr_q  <= {page_q, by_q};
`endif
          end
        end
`ifdef OAM_DMA_PARITY_ALIGN_EN
        ALIGN: begin
          state_q <= READ;
          rd_q    <= 1'b1;
          addr_q  <= {page_q, by_q};
        end
`endif
        READ: begin
          data_q  <= bus_din_i;
          state_q <= WRITE;
          wr_q    <= 1'b1;
          addr_q  <= OAM_DATA_ADDR;
          dout_q  <= bus_din_i;
        end
        WRITE: begin
          by_q <= nxt_by;
          if (by_q == LAST_BY) begin
            state_q <= IDLE;
            bflg_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= READ;
            rd_q    <= 1'b1;
            addr_q  <= {page_q, nxt_by};
          end
        end
        default: begin
          state_q <= IDLE;
          bflg_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dma_bflg_o = bflg_q;
  assign dma_by_o   = by_q;
  assign bus_addr_o = addr_q;
  assign bus_rd_o   = rd_q;
  assign bus_wr_o   = wr_q;
  assign bus_dout_o = dout_q;
  assign dma_done_o = done_q;

endmodule

// File: tb/tb_oam_dma_ctl.sv
// Bench for oam_dma_ctl: random memory image and random transfers, checked
// against transaction-level expectations (addresses, data, cycle counts).
module tb_oam_dma_ctl;

  logic        clk = 1'b0;
  logic        b_rst;
  logic [15:0] cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic        cpu_halted;
  logic [7:0]  bus_din;
  logic        dma_bflg;
  logic [7:0]  dma_by;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_dout;
  logic        dma_done;

  logic [7:0] mem [0:65535];
  int  tests = 0;
  int  fails = 0;
  logic tb_odd = 1'b0;  // expected APU parity during the current cycle

  always #5 clk = ~clk;

  assign bus_din = mem[bus_addr];

  oam_dma_ctl dut (
    .clk_i        (clk),
    .b_rst_i      (b_rst),
    .cpu_addr_i   (cpu_addr),
    .cpu_wr_i     (cpu_wr),
    .cpu_dout_i   (cpu_dout),
    .cpu_halted_i (cpu_halted),
    .bus_din_i    (bus_din),
    .dma_bflg_o   (dma_bflg),
    .dma_by_o     (dma_by),
    .bus_addr_o   (bus_addr),
    .bus_rd_o     (bus_rd),
    .bus_wr_o     (bus_wr),
    .bus_dout_o   (bus_dout),
    .dma_done_o   (dma_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; returns at the following negedge with outputs settled.
  task automatic tick();
    @(posedge clk);
    tb_odd = b_rst ? ~tb_odd : 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bflg"}, 32'(dma_bflg), 0);
    chk({tag, "_rd"},   32'(bus_rd),   0);
    chk({tag, "_wr"},   32'(bus_wr),   0);
    chk({tag, "_addr"}, 32'(bus_addr), 0);
    chk({tag, "_dout"}, 32'(bus_dout), 0);
    chk({tag, "_by"},   32'(dma_by),   0);
    chk({tag, "_done"}, 32'(dma_done), 0);
  endtask

  // Arrange that the first HALT cycle after the next trigger has parity 'want'.
  task automatic set_phase(input logic want);
    if (tb_odd == want) tick();
  endtask

  // Trigger one transfer and check it end to end.
  // retrig_by / rst_by: byte index at which to re-trigger / reset (-1 = none).
  task automatic run_xfer(input logic [7:0] pg, input int hdly,
                          input int retrig_by, input int rst_by);
    int rd_idx = 0, wr_idx = 0, bflg_cnt = 0, done_cnt = 0;
    int first_rd = -1, align = 0, done_cyc = -1;
    bit aborted = 0;
    cpu_addr = 16'h4014; cpu_wr = 1'b1; cpu_dout = pg; cpu_halted = 1'b0;
    tick();
    cpu_wr = 1'b0; cpu_addr = 16'h0000;
    for (int cyc = 0; cyc < 700; cyc++) begin
      cpu_wr = 1'b0;
      cpu_addr = 16'h0000;
      cpu_halted = (cyc >= hdly);
`ifdef OAM_DMA_PARITY_ALIGN_EN
      if (cyc == hdly) align = tb_odd ? 0 : 1;
`endif
      if (dma_bflg) bflg_cnt++;
      if (cyc <= hdly) chk("no_bus_before_halt", {30'd0, bus_rd, bus_wr}, 0);
      if (bus_rd) begin
        if (first_rd < 0) first_rd = cyc;
        chk("rd_addr", 32'(bus_addr), {16'd0, pg, 8'(rd_idx)});
        chk("rd_by", 32'(dma_by), 32'(rd_idx & 255));
`ifdef OAM_DMA_PARITY_ALIGN_EN
        chk("rd_parity", 32'(tb_odd), 0);
`endif
        if (rd_idx == retrig_by) begin
          cpu_addr = 16'h4014; cpu_wr = 1'b1; cpu_dout = 8'h05;
        end
        if (rd_idx == rst_by) begin
          b_rst = 1'b0;
          tick();
          chk_zero("rst_mid");
          b_rst = 1'b1;
          cpu_halted = 1'b0;
          for (int k = 0; k < 4; k++) begin
            tick();
            chk("rst_no_done", 32'(dma_done), 0);
            chk("rst_no_bflg", 32'(dma_bflg), 0);
          end
          aborted = 1;
          break;
        end
        rd_idx++;
      end
      if (bus_wr) begin
        chk("wr_addr", 32'(bus_addr), 32'h2004);
        chk("wr_data", 32'(bus_dout), 32'(mem[{pg, 8'(wr_idx)}]));
`ifdef OAM_DMA_PARITY_ALIGN_EN
        chk("wr_parity", 32'(tb_odd), 1);
`endif
        wr_idx++;
      end
      if (dma_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_bflg_low", 32'(dma_bflg), 0);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      tick();
    end
    cpu_halted = 1'b0;
    cpu_wr = 1'b0;
    if (!aborted) begin
      chk("first_rd_cycle", 32'(first_rd), 32'(hdly + 1 + align));
      chk("bflg_cycles", 32'(bflg_cnt), 32'(hdly + align + 513));
      chk("done_cycle", 32'(done_cyc), 32'(hdly + align + 513));
      chk("done_pulses", 32'(done_cnt), 1);
      chk("reads", 32'(rd_idx), 256);
      chk("writes", 32'(wr_idx), 256);
      chk("by_wrapped", 32'(dma_by), 0);
    end
  endtask

  initial begin
    b_rst = 1'b0; cpu_addr = '0; cpu_wr = 1'b0; cpu_dout = '0; cpu_halted = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    repeat (3) tick();
    chk_zero("reset");
    b_rst = 1'b1;
    tick();
    chk_zero("idle");

    // Write to a neighbouring register must not start anything.
    cpu_addr = 16'h4015; cpu_wr = 1'b1; cpu_dout = 8'h02;
    tick();
    cpu_wr = 1'b0;
    tick();
    chk("no_trig_bflg", 32'(dma_bflg), 0);

    set_phase(1'b1); run_xfer(8'h02, 0, -1, -1);   // even start
    set_phase(1'b0); run_xfer(8'h02, 0, -1, -1);   // odd start
    run_xfer(8'h02, 2, -1, -1);                    // delayed halt
    run_xfer(8'h02, 0, 16, -1);                    // ignored re-trigger
    run_xfer(8'h02, 0, -1, 128);                   // reset mid-transfer
    run_xfer(8'hFF, 0, -1, -1);                    // top page, no carry
    for (int n = 0; n < 2; n++)
      run_xfer(8'($urandom), int'($urandom_range(0, 5)), -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctl.md
# oam_dma_ctl

Sprite DMA controller for the NES CPU. A CPU write to register 0x4014 starts the controller, which requests the CPU bus from the control unit via `dma_bflg`. It then copies 256 bytes from page `{page, 8'h00}` into PPU OAM through 0x2004. It sits beside the control unit: its `dma_bflg` and `dma_by` feed the CU FSM inputs, and it drives the shared CPU bus while the CPU is halted.

## Interface
Parameters:
- `DMA_REG_ADDR`, 16'h4014, trigger register address
- `OAM_DATA_ADDR`, 16'h2004, OAM write-port address
- `XFER_LEN`, 256, bytes per transfer; `dma_by` is 8 bits wide

Ports:
- `clk`  in  1  CPU clock
- `b_rst`  in  1  reset; synchronous, active-low
- `cpu_addr`  in  16  CPU address bus
- `cpu_wr`  in  1  CPU write strobe, one cycle
- `cpu_dout`  in  8  CPU write data
- `cpu_halted`  in  1  CU acknowledges the halt; the CU asserts it only on CPU read cycles
- `bus_din`  in  8  read data from the shared bus
- `dma_bflg`  out  1  DMA requests or owns the bus; goes to the CU FSM
- `dma_by`  out  8  current byte index; goes to the CU
- `bus_addr`  out  16  DMA bus address
- `bus_rd`  out  1  DMA read cycle
- `bus_wr`  out  1  DMA write cycle
- `bus_dout`  out  8  DMA write data
- `dma_done`  out  1  one-cycle pulse when a transfer completes

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- Free-running parity flop `apu_odd`: reset value 0, toggles every clock.
- IDLE:
  - Trigger condition: `cpu_wr && cpu_addr==DMA_REG_ADDR`.
  - On trigger: latch `page <= cpu_dout`, clear `dma_by`, go to HALT.
- HALT:
  - `dma_bflg`=1; no bus activity.
  - Stays in HALT while `cpu_halted`=0.
  - When `cpu_halted`=1: if `apu_odd`=1 go to READ, else go to ALIGN.
- ALIGN: one idle cycle with `dma_bflg`=1, then READ.
- READ:
  - `bus_addr={page,dma_by}`, `bus_rd`=1.
  - `bus_din` is captured into `data_r` at the end of the cycle.
  - Next state is WRITE.
- WRITE:
  - `bus_addr=OAM_DATA_ADDR`, `bus_wr`=1, `bus_dout=data_r`.
  - `dma_by` increments (wraps 255→0, never carries into `page`).
  - If `dma_by`=255: go to IDLE and pulse `dma_done`. Otherwise go to READ.
- Writes to `DMA_REG_ADDR` outside IDLE are ignored; `page` is unchanged.
- `b_nmi`/`b_irq` are not inputs to this block. Interrupts stay latched by the CU capture logic for the whole transfer.
- Reset values: all outputs 0, state IDLE, `page`=0, `data_r`=0, `apu_odd`=0.
- Reset mid-transfer aborts the transfer with no `dma_done` pulse. A later trigger restarts at byte 0.

## Timing
- All outputs are decoded from registered state (Moore) and are valid for the whole cycle.
- Trigger sampled at edge N: `dma_bflg` is 1 from cycle N+1 until the last WRITE cycle inclusive.
- The cycle after the last WRITE: `dma_bflg`=0 and `dma_done`=1.
- Halted length, counted from the first `cpu_halted`=1 cycle: 1 HALT + 0 or 1 ALIGN + 512 = 513 or 514 cycles.
- Each HALT cycle spent waiting for `cpu_halted` adds one cycle of `dma_bflg`.
- READ cycles always fall on `apu_odd`=0; WRITE cycles on `apu_odd`=1.

## Configuration
- `OAM_DMA_PARITY_ALIGN_EN` defined: parity alignment as described above (513 or 514 cycles).
- `OAM_DMA_PARITY_ALIGN_EN` undefined:
  - ALIGN state and `apu_odd` are removed.
  - HALT goes straight to READ.
  - Transfer is always 513 halted cycles, with no parity relation.

## Structure
- Package `nes_dma_pkg`:
  - `dma_state_t` enum (IDLE, HALT, ALIGN, READ, WRITE).
  - Constants `OAM_DMA_REG`, `OAM_DATA_REG`, `DMA_XFER_LEN`.
- One sub-module, `apu_cyc_parity`: the parity flop.
  - Compiled only under `OAM_DMA_PARITY_ALIGN_EN`.
  - Separate so the APU can share it later.
- The top holds the FSM, `page`, `data_r` and the `dma_by` counter.

## Test plan
- Even start: write 8'h02 to 0x4014 with `cpu_halted`=1 immediately and `apu_odd`=1 in the HALT cycle → reads 0x0200..0x02FF, matching data written to 0x2004; `dma_bflg` high for 513 cycles; one `dma_done` pulse.
- Odd start: same stimulus but `apu_odd`=0 in the HALT cycle → one ALIGN cycle; `dma_bflg` high for 514 cycles; all READs on `apu_odd`=0.
- Delayed halt: hold `cpu_halted`=0 for 2 cycles after trigger → `dma_bflg` high 2 extra cycles; no `bus_rd` or `bus_wr` before the halt is acknowledged.
- Re-trigger: write 8'h05 to 0x4014 at `dma_by`=8'h10 → ignored; addresses stay on page 0x02; transfer completes normally.
- Reset mid-transfer: drop `b_rst` at `dma_by`=8'h80 → next cycle all outputs are 0 and there is no `dma_done`; a new trigger with page 8'hFF reads 0xFF00..0xFFFF with no carry into the page.
